// File: rtl/frame_buffer.sv
// Double-buffered 16-bit pixel store: raster writes land in the back buffer, scanout reads the front.
// A CPU swap request is held until the next vertical-blank rising edge so a frame is never torn.
module frame_buffer #(
  parameter  int FB_WIDTH  = 400,
  parameter  int FB_HEIGHT = 240,
  localparam int XW        = $clog2(FB_WIDTH) + 1,
  localparam int YW        = $clog2(FB_HEIGHT) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] wr_x,
  input  logic [YW-1:0] wr_y,
  input  logic [15:0]   wr_color,
  input  logic          wr_en,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  input  logic          rd_en,
  output logic [15:0]   rd_color,
  output logic          rd_valid,
  input  logic          vblank,
  input  logic          swap_req,
  output logic          swap_pending,
  output logic          front_sel
);

  localparam int PIX = FB_WIDTH * FB_HEIGHT;
  localparam int LW  = $clog2(PIX);
  localparam int AW  = LW + 1;
  localparam logic [XW-1:0] X_LIM = XW'(FB_WIDTH);
  localparam logic [YW-1:0] Y_LIM = YW'(FB_HEIGHT);
  localparam logic [LW-1:0] W_MUL = LW'(FB_WIDTH);

  typedef enum logic {S_IDLE = 1'b0, S_PENDING = 1'b1} state_t;

  function automatic logic [LW-1:0] lin_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return LW'(y) * W_MUL + LW'(x);
  endfunction

  // ---------------------------------------------------------------- swap FSM
  state_t state_q, state_d;
  logic   front_sel_q, front_sel_d;
  logic   vblank_q;
  logic   vblank_rise;
  logic   take_swap;

  assign vblank_rise = vblank && !vblank_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      front_sel_q <= 1'b0;
      vblank_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      vblank_q    <= vblank;
    end
  end

  // A request coinciding with an edge is served on that edge and never shows as pending.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (swap_req && !vblank_rise) state_d = S_PENDING;
      S_PENDING: if (vblank_rise)              state_d = S_IDLE;
      default:                                 state_d = S_IDLE;
    endcase
  end

  always_comb begin
    swap_pending = (state_q == S_PENDING);
    take_swap    = 1'b0;
    case (state_q)
      S_IDLE:    take_swap = swap_req && vblank_rise;
      S_PENDING: take_swap = vblank_rise;
      default:   take_swap = 1'b0;
    endcase
    front_sel_d = front_sel_q ^ take_swap;
  end

  assign front_sel = front_sel_q;

  // ---------------------------------------------------------------- write stage 1
  logic          wr_ok;
  logic [AW-1:0] wr_addr_d, wr_addr_q;
  logic          wr_v_q;
  logic [15:0]   wr_data_q;

  always_comb begin
    wr_ok     = wr_en && (wr_x < X_LIM) && (wr_y < Y_LIM);
    wr_addr_d = {~front_sel_q, lin_addr(wr_x, wr_y)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_v_q <= 1'b0;
    end else begin
      wr_v_q <= wr_ok;
    end
    wr_addr_q <= wr_addr_d;
    wr_data_q <= wr_color;
  end

  // ---------------------------------------------------------------- read stage 1
  logic          rd_hit_d;
  logic [AW-1:0] rd_addr_d, rd_addr_q;
  logic          rd_v_q, rd_hit_q;

  always_comb begin
    rd_hit_d  = (rd_x < X_LIM) && (rd_y < Y_LIM);
    rd_addr_d = {front_sel_q, lin_addr(rd_x, rd_y)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v_q   <= 1'b0;
      rd_hit_q <= 1'b0;
    end else begin
      rd_v_q   <= rd_en;
      rd_hit_q <= rd_en && rd_hit_d;
    end
    rd_addr_q <= rd_addr_d;
  end

  // ---------------------------------------------------------------- RAM
  // Buffer select is the address MSB, so each half spans a full power of two.
  logic [15:0] mem [0:(2**AW)-1];
  logic [15:0] ram_q;

  // Same-block read and write give read-first behaviour on an address collision.
  always_ff @(posedge clk) begin
    if (wr_v_q && !reset) begin
      mem[wr_addr_q] <= wr_data_q;
    end
    if (rd_v_q && rd_hit_q) begin
      ram_q <= mem[rd_addr_q];
    end
  end

  // ---------------------------------------------------------------- read stage 2
  logic rd_valid_q, rd_hit2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_hit2_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_v_q;
      rd_hit2_q  <= rd_hit_q;
    end
  end

  // Out-of-range reads never touch the RAM and report zero.
  assign rd_valid = rd_valid_q;
  assign rd_color = (rd_valid_q && rd_hit2_q) ? ram_q : 16'h0000;

endmodule

// File: tb/tb_frame_buffer.sv
// Scoreboard bench for frame_buffer: reads push expected data, a negedge monitor pops and compares.
module tb_frame_buffer;

  localparam int XW = 10;
  localparam int YW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [XW-1:0] wr_x, rd_x;
  logic [YW-1:0] wr_y, rd_y;
  logic [15:0]   wr_color;
  logic          wr_en, rd_en;
  logic [15:0]   rd_color;
  logic          rd_valid;
  logic          vblank, swap_req;
  logic          swap_pending, front_sel;

  frame_buffer #(.FB_WIDTH(400), .FB_HEIGHT(240)) dut (
    .clk(clk), .reset(reset),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .wr_en(wr_en),
    .rd_x(rd_x), .rd_y(rd_y), .rd_en(rd_en),
    .rd_color(rd_color), .rd_valid(rd_valid),
    .vblank(vblank), .swap_req(swap_req),
    .swap_pending(swap_pending), .front_sel(front_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] color;
    int          cyc;
    int          x;
    int          y;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic exp_front = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Monitor: every valid read output is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && rd_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rd_valid actual=1 required=0 color=%h", rd_color);
      end else begin
        exp_t e;
        e = q.pop_front();
        total++;
        if (rd_color !== e.color || cyc != e.cyc + 2) begin
          bad++;
          $display("FAIL read(%0d,%0d) actual=%h@%0d required=%h@%0d",
                   e.x, e.y, rd_color, cyc, e.color, e.cyc + 2);
        end else begin
          $display("ok   read(%0d,%0d) color=%h latency=2", e.x, e.y, rd_color);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    swap_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input int x, input int y, input logic [15:0] c);
    wr_x = XW'(x); wr_y = YW'(y); wr_color = c; wr_en = 1'b1;
    step();
  endtask

  task automatic rd(input int x, input int y, input logic [15:0] c);
    exp_t e;
    rd_x = XW'(x); rd_y = YW'(y); rd_en = 1'b1;
    e.color = c; e.cyc = cyc; e.x = x; e.y = y;
    q.push_back(e);
    step();
  endtask

  task automatic do_swap();
    swap_req = 1'b1; step();
    vblank = 1'b1;   step();
    vblank = 1'b0;   step();
    exp_front = ~exp_front;
    check("swap_front_sel", 32'(front_sel), 32'(exp_front));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_x = '0; wr_y = '0; wr_color = '0; wr_en = 1'b0;
    rd_x = '0; rd_y = '0; rd_en = 1'b0; vblank = 1'b0; swap_req = 1'b0;
    idle(3);
    reset = 1'b0;
    check("reset_front_sel", 32'(front_sel), 0);
    check("reset_swap_pending", 32'(swap_pending), 0);
    check("reset_rd_valid", 32'(rd_valid), 0);
    check("reset_rd_color", 32'(rd_color), 0);

    // Basic write, deferred swap, read back
    wr(10, 20, 16'hF801);
    swap_req = 1'b1; step();
    check("pending_after_req", 32'(swap_pending), 1);
    idle(2);
    check("pending_held", 32'(swap_pending), 1);
    check("front_before_edge", 32'(front_sel), 0);
    vblank = 1'b1; step();
    exp_front = 1'b1;
    check("front_after_edge", 32'(front_sel), 1);
    check("pending_after_edge", 32'(swap_pending), 0);
    vblank = 1'b0; step();
    rd(10, 20, 16'hF801);
    idle(4);

    // Range checks: back buffer is 0 now
    wr(0, 0, 16'h1111);
    wr(399, 239, 16'h2222);
    wr(0, 1, 16'h3333);
    wr(400, 0, 16'hFFFF);
    wr(0, 240, 16'hFFFF);
    idle(2);
    do_swap();
    rd(0, 0, 16'h1111);
    rd(399, 239, 16'h2222);
    rd(0, 1, 16'h3333);
    rd(400, 5, 16'h0000);
    rd(5, 240, 16'h0000);
    idle(4);

    // swap_req coincident with vblank rising edge
    swap_req = 1'b1; vblank = 1'b1; step();
    exp_front = ~exp_front;
    check("coincident_front", 32'(front_sel), 32'(exp_front));
    check("coincident_pending", 32'(swap_pending), 0);
    vblank = 1'b0; step();
    check("coincident_pending_later", 32'(swap_pending), 0);

    // Second request while pending is not queued
    swap_req = 1'b1; step();
    swap_req = 1'b1; step();
    check("double_req_pending", 32'(swap_pending), 1);
    vblank = 1'b1; step();
    exp_front = ~exp_front;
    vblank = 1'b0; idle(3);
    vblank = 1'b1; step();
    vblank = 1'b0; step();
    check("double_req_one_toggle", 32'(front_sel), 32'(exp_front));
    check("double_req_idle", 32'(swap_pending), 0);

    // Request with vblank already high waits for a fresh edge
    vblank = 1'b1; idle(2);
    swap_req = 1'b1; idle(3);
    check("vb_high_pending", 32'(swap_pending), 1);
    check("vb_high_no_toggle", 32'(front_sel), 32'(exp_front));
    vblank = 1'b0; step();
    check("vb_low_no_toggle", 32'(front_sel), 32'(exp_front));
    vblank = 1'b1; step();
    exp_front = ~exp_front;
    check("vb_new_edge_toggle", 32'(front_sel), 32'(exp_front));
    check("vb_new_edge_idle", 32'(swap_pending), 0);
    vblank = 1'b0; step();

    // Full scanline burst write and read
    for (int i = 0; i < 400; i++) wr(i, 0, 16'(i * 3 + 16'h0500));
    idle(2);
    do_swap();
    for (int i = 0; i < 400; i++) rd(i, 0, 16'(i * 3 + 16'h0500));
    idle(4);

    // Reset during PENDING with a write in stage 1
    if (exp_front != 1'b0) do_swap();
    wr(7, 7, 16'hAAAA);
    idle(2);
    swap_req = 1'b1; step();
    check("pre_reset_pending", 32'(swap_pending), 1);
    wr_x = 10'd7; wr_y = 9'd7; wr_color = 16'hBBBB; wr_en = 1'b1;
    step();
    reset = 1'b1; step();
    reset = 1'b0;
    exp_front = 1'b0;
    check("mid_reset_front", 32'(front_sel), 0);
    check("mid_reset_pending", 32'(swap_pending), 0);
    idle(2);
    check("mid_reset_still_idle", 32'(swap_pending), 0);
    do_swap();
    rd(7, 7, 16'hAAAA);
    idle(5);

    check("scoreboard_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
